// File: rtl/reset_request_generator.sv
// Originating end of a cross-domain reset handshake: stretches a request into a minimum-width
// active-low reset, waits for the downstream domain to confirm assert/release, then holds off.
module reset_request_generator #(
    parameter int unsigned ASSERT_CYCLES  = 16,
    parameter int unsigned HOLDOFF_CYCLES = 8,
    parameter int unsigned ACK_TIMEOUT    = 255,
    parameter bit          ACK_ENABLE     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic rst_out_n,
    input  logic ack_async,
    output logic busy,
    output logic done,
    output logic timeout,
    input  logic timeout_clr
);

    localparam int unsigned MaxCyc = (ASSERT_CYCLES > HOLDOFF_CYCLES) ? ASSERT_CYCLES
                                                                       : HOLDOFF_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);
    localparam int unsigned TmoW   = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StAssert,
        StWaitLo,
        StRelease,
        StHoldoff
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q;
    logic [TmoW-1:0]   tmo_q;
    logic              pending_q;
    logic              rst_out_n_q, busy_q, done_q, timeout_q;
    logic              ack_meta_q, ack_s_q;

    logic              ack_s;
    logic              pend_now;
    logic              tmo_set;
    logic              cnt_last, tmo_last;
    logic              enter_assert, enter_hold, enter_wait, enter_idle;
    state_e            after_release;

    assign ack_s = ack_s_q;

    // Two-flop synchronizer; resets to "downstream out of reset" so no false ack is seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_meta_q <= 1'b1;
            ack_s_q    <= 1'b1;
        end else begin
            ack_meta_q <= ack_async;
            ack_s_q    <= ack_meta_q;
        end
    end

    always_comb begin
        pend_now = pending_q |
                   (req & ((state_q == StRelease) | (state_q == StHoldoff)));
        cnt_last = (cnt_q == CntW'(1));
        tmo_last = (tmo_q == TmoW'(1));
        // With a zero hold-off the decision normally made at the end of HOLDOFF happens here.
        if (HOLDOFF_CYCLES != 0) begin
            after_release = StHoldoff;
        end else if (pend_now) begin
            after_release = StAssert;
        end else begin
            after_release = StIdle;
        end

        state_d = state_q;
        tmo_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) state_d = StAssert;
            end
            StAssert: begin
                if (cnt_last) state_d = ACK_ENABLE ? StWaitLo : after_release;
            end
            StWaitLo: begin
                if (!ack_s) begin
                    state_d = StRelease;
                end else if (tmo_last) begin
                    tmo_set = 1'b1;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (ack_s) begin
                    state_d = after_release;
                end else if (tmo_last) begin
                    tmo_set = 1'b1;
                    state_d = after_release;
                end
            end
            StHoldoff: begin
                if (cnt_last) state_d = pend_now ? StAssert : StIdle;
            end
            default: state_d = StAssert;
        endcase

        enter_assert = (state_d == StAssert) && (state_q != StAssert);
        enter_hold   = (state_d == StHoldoff) && (state_q != StHoldoff);
        enter_wait   = ((state_d == StWaitLo) && (state_q != StWaitLo)) ||
                       ((state_d == StRelease) && (state_q != StRelease));
        enter_idle   = (state_d == StIdle) && (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StAssert;
            cnt_q       <= CntW'(ASSERT_CYCLES);
            tmo_q       <= TmoW'(ACK_TIMEOUT);
            pending_q   <= 1'b0;
            rst_out_n_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q <= state_d;

            if (enter_assert) begin
                cnt_q <= CntW'(ASSERT_CYCLES);
            end else if (enter_hold) begin
                cnt_q <= CntW'(HOLDOFF_CYCLES);
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CntW'(1);
            end

            if (enter_wait) begin
                tmo_q <= TmoW'(ACK_TIMEOUT);
            end else if (tmo_q != '0) begin
                tmo_q <= tmo_q - TmoW'(1);
            end

            pending_q   <= enter_assert ? 1'b0 : pend_now;
            rst_out_n_q <= !((state_d == StAssert) || (state_d == StWaitLo));
            busy_q      <= (state_d != StIdle);
            done_q      <= enter_idle;

            if (tmo_set) begin
                timeout_q <= 1'b1;
            end else if (timeout_clr) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign rst_out_n = rst_out_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_reset_request_generator.sv
// Bench for reset_request_generator: vector table on an ACK_ENABLE=0 instance, directed and
// random stimulus on a default instance checked every cycle against a phase/age model.
module tb_reset_request_generator;

    localparam int MA = 16;
    localparam int MH = 8;
    localparam int MT = 255;
    localparam int PI = 0, PA = 1, PW = 2, PR = 3, PH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a = 1'b1, req_a = 1'b0, ack_a = 1'b1, clr_a = 1'b0;
    logic rst_n_a, busy_a, done_a, tmo_a;
    logic reset_b = 1'b1, req_b = 1'b0, ack_b = 1'b0, clr_b = 1'b0;
    logic rst_n_b, busy_b, done_b, tmo_b;

    reset_request_generator #(
        .ASSERT_CYCLES(16), .HOLDOFF_CYCLES(8), .ACK_TIMEOUT(255), .ACK_ENABLE(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset_a), .req(req_a), .rst_out_n(rst_n_a), .ack_async(ack_a),
        .busy(busy_a), .done(done_a), .timeout(tmo_a), .timeout_clr(clr_a)
    );

    reset_request_generator #(
        .ASSERT_CYCLES(16), .HOLDOFF_CYCLES(8), .ACK_TIMEOUT(255), .ACK_ENABLE(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset_b), .req(req_b), .rst_out_n(rst_n_b), .ack_async(ack_b),
        .busy(busy_b), .done(done_b), .timeout(tmo_b), .timeout_clr(clr_b)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream domain: ack follows rst_out_n after a delay, stuck high, or random.
    int       ack_mode = 0;
    int       ack_dly  = 3;
    bit [7:0] hist     = 8'h00;
    always @(negedge clk) begin
        hist = {hist[6:0], rst_n_a};
        if (ack_mode == 0)      ack_a = hist[ack_dly-1];
        else if (ack_mode == 1) ack_a = 1'b1;
        else                    ack_a = 1'($urandom_range(0, 1));
    end

    // Reference model: phase plus cycles-spent-in-phase, decisions taken per edge.
    int m_ph = PA;
    int m_age = 0;
    bit m_pend = 0, m_tmo = 0, m_done = 0, m_s1 = 1, m_s2 = 1;

    task automatic m_enter(input int p);
        m_ph  = p;
        m_age = 0;
        if (p == PA) m_pend = 0;
        if (p == PI) m_done = 1;
    endtask

    task automatic m_post();
        if (MH > 0)      m_enter(PH);
        else if (m_pend) m_enter(PA);
        else             m_enter(PI);
    endtask

    always @(posedge clk) begin
        bit acks, tset;
        if (reset_a) begin
            m_ph = PA; m_age = 0; m_pend = 0; m_tmo = 0; m_done = 0; m_s1 = 1; m_s2 = 1;
        end else begin
            acks = m_s2; m_s2 = m_s1; m_s1 = ack_a;
            m_done = 0; tset = 0; m_age++;
            if ((m_ph == PR || m_ph == PH) && req_a) m_pend = 1;
            case (m_ph)
                PI: if (req_a) m_enter(PA);
                PA: if (m_age == MA) m_enter(PW);
                PW: if (!acks) m_enter(PR);
                    else if (m_age == MT) begin tset = 1; m_enter(PR); end
                PR: if (acks) m_post();
                    else if (m_age == MT) begin tset = 1; m_post(); end
                PH: if (m_age == MH) begin
                        if (m_pend) m_enter(PA);
                        else        m_enter(PI);
                    end
                default: ;
            endcase
            if (tset)       m_tmo = 1;
            else if (clr_a) m_tmo = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_rst_out_n", int'(rst_n_a), (m_ph == PA || m_ph == PW) ? 0 : 1);
            chk("model_busy", int'(busy_a), (m_ph != PI) ? 1 : 0);
            chk("model_done", int'(done_a), int'(m_done));
            chk("model_timeout", int'(tmo_a), int'(m_tmo));
        end
    end

    // Runs until dut_a is idle; reports low samples, done pulses, falling edges of rst_out_n.
    task automatic wait_idle(output int lowc, output int donec, output int fallc,
                             output int dbf);
        int cyc;
        bit prev;
        cyc = 0; lowc = 0; donec = 0; fallc = 0; dbf = 0;
        prev = rst_n_a;
        while (busy_a && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (!rst_n_a) lowc++;
            if (prev && !rst_n_a) begin
                if (fallc == 0) dbf = donec;
                fallc++;
            end
            prev = rst_n_a;
            donec += int'(done_a);
        end
        chk("idle_within_budget", (cyc < 2000) ? 1 : 0, 1);
    endtask

    task automatic count_low(output int lowc);
        lowc = 0;
        while (!rst_n_a && lowc < 2000) begin
            @(negedge clk);
            if (!rst_n_a) lowc++;
        end
    endtask

    typedef struct {
        bit rst;
        bit req;
        int n;
        bit e_rst_n;
        bit e_busy;
        bit e_done;
    } vec_t;

    vec_t tbl[26];

    initial begin
        int lowc, donec, fallc, dbf;

        tbl[0]  = '{1, 0, 3, 0, 1, 0};   // in reset
        tbl[1]  = '{0, 0, 15, 0, 1, 0};  // power-on assert
        tbl[2]  = '{0, 0, 1, 1, 1, 0};   // into hold-off
        tbl[3]  = '{0, 0, 7, 1, 1, 0};
        tbl[4]  = '{0, 0, 1, 1, 0, 1};   // idle, done
        tbl[5]  = '{0, 0, 1, 1, 0, 0};
        tbl[6]  = '{0, 1, 1, 0, 1, 0};   // request accepted next cycle
        tbl[7]  = '{0, 1, 14, 0, 1, 0};  // requests in assert ignored
        tbl[8]  = '{0, 0, 1, 0, 1, 0};
        tbl[9]  = '{0, 0, 1, 1, 1, 0};
        tbl[10] = '{0, 1, 1, 1, 1, 0};   // three requests in hold-off
        tbl[11] = '{0, 0, 2, 1, 1, 0};
        tbl[12] = '{0, 1, 1, 1, 1, 0};
        tbl[13] = '{0, 0, 3, 1, 1, 0};
        tbl[14] = '{0, 1, 1, 0, 1, 0};   // pending: straight back to assert, no done
        tbl[15] = '{0, 0, 15, 0, 1, 0};
        tbl[16] = '{0, 0, 1, 1, 1, 0};
        tbl[17] = '{0, 0, 7, 1, 1, 0};
        tbl[18] = '{0, 0, 1, 1, 0, 1};
        tbl[19] = '{0, 0, 1, 1, 0, 0};
        tbl[20] = '{0, 1, 1, 0, 1, 0};
        tbl[21] = '{0, 0, 5, 0, 1, 0};
        tbl[22] = '{1, 0, 1, 0, 1, 0};   // reset mid-assert
        tbl[23] = '{0, 0, 15, 0, 1, 0};  // full assert restarts
        tbl[24] = '{0, 0, 1, 1, 1, 0};
        tbl[25] = '{0, 0, 8, 1, 0, 1};

        @(negedge clk);
        chk_en = 1'b1;

        for (int i = 0; i < 26; i++) begin
            reset_b = tbl[i].rst;
            req_b   = tbl[i].req;
            for (int k = 0; k < tbl[i].n; k++) begin
                ack_b = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            chk($sformatf("noack_v%0d_rst_out_n", i), int'(rst_n_b), int'(tbl[i].e_rst_n));
            chk($sformatf("noack_v%0d_busy", i), int'(busy_b), int'(tbl[i].e_busy));
            chk($sformatf("noack_v%0d_done", i), int'(done_b), int'(tbl[i].e_done));
            chk($sformatf("noack_v%0d_timeout", i), int'(tmo_b), 0);
        end

        // Power-on of dut_a.
        ack_mode = 0; ack_dly = 3;
        repeat (4) @(negedge clk);
        chk("por_rst_out_n_in_reset", int'(rst_n_a), 0);
        chk("por_busy_in_reset", int'(busy_a), 1);
        reset_a = 1'b0;
        wait_idle(lowc, donec, fallc, dbf);
        chk("por_low_at_least_16", (lowc >= 16) ? 1 : 0, 1);
        chk("por_done_once", donec, 1);
        chk("por_idle_busy", int'(busy_a), 0);

        // Single request.
        repeat (3) @(negedge clk);
        req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        chk("req_low_next_cycle", int'(rst_n_a), 0);
        wait_idle(lowc, donec, fallc, dbf);
        chk("req_low_width", (lowc >= 16) ? 1 : 0, 1);
        chk("req_done_once", donec, 1);
        chk("req_no_timeout", int'(tmo_a), 0);

        // Ack stuck high: wait-low times out.
        ack_mode = 1;
        repeat (3) @(negedge clk);
        req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        count_low(lowc);
        chk("tmo_low_width", lowc + 1, MA + MT);
        chk("tmo_flag_set", int'(tmo_a), 1);
        wait_idle(lowc, donec, fallc, dbf);
        chk("tmo_done_once", donec, 1);
        chk("tmo_sticky", int'(tmo_a), 1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        chk("tmo_cleared", int'(tmo_a), 0);

        // Request during assert is absorbed.
        ack_mode = 0;
        repeat (3) @(negedge clk);
        req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        repeat (3) @(negedge clk);
        req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        wait_idle(lowc, donec, fallc, dbf);
        chk("busy_req_in_assert_no_extra", fallc, 0);
        chk("busy_req_in_assert_done", donec, 1);

        // Three requests after release collapse into one further sequence.
        repeat (2) @(negedge clk);
        req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        for (int k = 0; k < 400 && !rst_n_a; k++) @(negedge clk);
        chk("pend_released", int'(rst_n_a), 1);
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            req_a = 1'b1;
            @(negedge clk);
            req_a = 1'b0;
            @(negedge clk);
        end
        wait_idle(lowc, donec, fallc, dbf);
        chk("pend_one_more_sequence", fallc, 1);
        chk("pend_no_done_between", dbf, 0);
        chk("pend_done_once", donec, 1);

        // Reset in the middle of wait-low.
        ack_mode = 1;
        repeat (3) @(negedge clk);
        req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        repeat (20) @(negedge clk);
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        chk("midrst_rst_out_n", int'(rst_n_a), 0);
        chk("midrst_busy", int'(busy_a), 1);
        count_low(lowc);
        chk("midrst_full_restart", lowc, MA + MT - 1);
        wait_idle(lowc, donec, fallc, dbf);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                ack_mode = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 2)) : 0;
                ack_dly  = $urandom_range(1, 6);
            end
            reset_a = ($urandom_range(0, 499) == 0);
            req_a   = ($urandom_range(0, 9) == 0);
            clr_a   = ($urandom_range(0, 19) == 0);
            @(negedge clk);
        end
        reset_a = 1'b0; req_a = 1'b0; clr_a = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reset_request_generator.md
Name: reset_request_generator

Overview:
Originating end of a cross-domain reset handshake. Turns a single-cycle reset request in the clk domain into a registered, glitch-free, minimum-width active-low reset (rst_out_n) that drives the asyncrst_n input of a downstream domain's async reset synchronizer. It waits for that domain's synchronized rst_n (returned as ack_async) to confirm both assertion and release, then applies a hold-off before accepting the next request. Also issues a power-on reset of the downstream domain after its own reset.

Parameters:
ASSERT_CYCLES, 16, minimum cycles rst_out_n is held low; legal range is 1 or more.
HOLDOFF_CYCLES, 8, cycles after confirmed release before done/idle; 0 is legal (HOLDOFF is skipped).
ACK_TIMEOUT, 255, maximum cycles spent in each ack wait state before forcing progress; legal range is 1 or more.
ACK_ENABLE, 1, 1 = use the ack handshake; 0 = ignore ack_async and skip both wait states.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req  input  1  single-cycle reset request pulse; level is also accepted, sampled every cycle
rst_out_n  output  1  registered active-low reset to the downstream domain
ack_async  input  1  downstream rst_n, asynchronous to clk; 0 = downstream in reset
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on entering IDLE from HOLDOFF
timeout  output  1  sticky flag; set when an ack wait expires
timeout_clr  input  1  clears timeout; set takes priority if both occur in the same cycle

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values while reset=1: rst_out_n=0, busy=1, done=0, timeout=0, pending=0, sync flops=1. State is forced to ASSERT with the counter loaded to ASSERT_CYCLES.
- After reset deasserts, the power-on sequence runs: the downstream domain gets at least ASSERT_CYCLES low cycles.
- ack_async passes through a 2-flop synchronizer to form ack_s. There is 2-cycle latency; no logic reads ack_async directly.
- All outputs are registered. rst_out_n comes straight from a flop with no combinational decode.
- State machine:
  - IDLE: rst_out_n=1, busy=0. If req=1, the next state is ASSERT and rst_out_n=0 one cycle after req is sampled.
  - ASSERT: rst_out_n=0. Count down ASSERT_CYCLES, so rst_out_n is low for exactly ASSERT_CYCLES cycles in this state. At terminal count, go to WAIT_LO (ACK_ENABLE=1) or HOLDOFF (ACK_ENABLE=0; rst_out_n returns to 1 on entry).
  - WAIT_LO: rst_out_n stays 0 until ack_s=0, then go to RELEASE. After ACK_TIMEOUT cycles without ack_s=0, set timeout and go to RELEASE.
  - RELEASE: rst_out_n=1. Wait for ack_s=1, then go to HOLDOFF. The same timeout rule applies (set timeout, go to HOLDOFF).
  - HOLDOFF: rst_out_n=1. Count HOLDOFF_CYCLES. At terminal count:
    - pending=1: clear pending and go to ASSERT; done is not pulsed.
    - otherwise: go to IDLE with done=1 for one cycle.
- Requests outside IDLE:
  - req in ASSERT or WAIT_LO is ignored; the reset is already active.
  - req in RELEASE or HOLDOFF sets pending. Pending is one deep, so multiple requests collapse to one.
- Timeout counter: a single counter is reloaded on each wait-state entry. Its width is $clog2(ACK_TIMEOUT+1).
- The ASSERT/HOLDOFF counter width is $clog2(max(ASSERT_CYCLES,HOLDOFF_CYCLES)+1). There is no wrap; counters load on state entry.
- ack_s=0 already true on entering WAIT_LO: leave after 1 cycle. ack_s=1 already true on entering RELEASE: leave after 1 cycle.
- reset mid-sequence, in any state: immediately return to the reset values (rst_out_n=0) and restart the power-on sequence. pending is lost.
- req in the same cycle that reset deasserts is ignored; the power-on sequence is already running.

Test Plan:
- Power-on reset: reset high 5 cycles, then low; ack_async follows rst_out_n after 3 cycles. Required: rst_out_n low during reset plus at least 16 cycles after; busy=1 throughout; done pulses once; afterwards IDLE with busy=0.
- Single request from IDLE: req pulse at cycle T, ack model 3-cycle delay. Required: rst_out_n=0 at T+1, low for 16 plus the wait-state dwell, then 1; done pulses exactly 8 cycles after ack_s rises; timeout=0.
- Ack timeout: ack_async tied to 1. Required: rst_out_n low for 16+255 cycles; timeout=1 and stays set; done still pulses. timeout_clr then drops timeout to 0 next cycle.
- Requests while busy: req in ASSERT produces no extra sequence. Three reqs during HOLDOFF produce exactly one further ASSERT, with no done between the two sequences.
- ACK_ENABLE=0, ack_async floating or X: required sequence is 16 cycles low, 8 cycles HOLDOFF, then done, with no X on any output.
- Reset mid-WAIT_LO: assert reset 1 cycle. Required: rst_out_n stays 0, pending=0, and a full 16-cycle ASSERT restarts after deassert.
